// File: rtl/score_keeper_if.sv
// Bundle between the ball/collision logic, the score keeper and the digit displays.
// The score keeper sits on the slave side. The game/test side drives through master.
interface score_keeper_if;
  logic       start;
  logic       point_p1;
  logic       point_p2;
  logic       frame_tick;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       serve;
  logic       serve_dir;
  logic       game_over;
  logic [1:0] winner;

  modport slave (
    input  start, point_p1, point_p2, frame_tick,
    output score_p1, score_p2, serve, serve_dir, game_over, winner
  );

  modport master (
    output start, point_p1, point_p2, frame_tick,
    input  score_p1, score_p2, serve, serve_dir, game_over, winner
  );
endinterface

// File: rtl/score_keeper.sv
// Counts point events for both players and sequences the serve hold-off and game over.
// It republishes the scores to the digit displays once per frame.
module score_keeper #(
  parameter int MAX_SCORE      = 9,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  score_keeper_if.slave bus_io
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    HOLDOFF   = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  localparam logic [3:0]       MaxScore = 4'(MAX_SCORE);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       scoreP1_q, scoreP1_d;
  logic [3:0]       scoreP2_q, scoreP2_d;
  logic [3:0]       shownP1_q, shownP2_q;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic             serve_q, serve_d;
  logic             serveDir_q, serveDir_d;
  logic             gameOver_q, gameOver_d;
  logic [1:0]       winner_q, winner_d;
  logic             pointP1_q, pointP2_q;
  logic             eventP1, eventP2;
  logic [3:0]       incP1, incP2;

  // Ball logic holds the point level for many cycles, so only the rising edge counts.
  assign eventP1 = bus_io.point_p1 & ~pointP1_q;
  assign eventP2 = bus_io.point_p2 & ~pointP2_q;
  assign incP1   = (scoreP1_q >= MaxScore) ? MaxScore : scoreP1_q + 4'd1;
  assign incP2   = (scoreP2_q >= MaxScore) ? MaxScore : scoreP2_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scoreP1_q  <= 4'd0;
      scoreP2_q  <= 4'd0;
      holdCnt_q  <= '0;
      serve_q    <= 1'b0;
      serveDir_q <= 1'b0;
      gameOver_q <= 1'b0;
      winner_q   <= 2'b00;
      pointP1_q  <= 1'b0;
      pointP2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      scoreP1_q  <= scoreP1_d;
      scoreP2_q  <= scoreP2_d;
      holdCnt_q  <= holdCnt_d;
      serve_q    <= serve_d;
      serveDir_q <= serveDir_d;
      gameOver_q <= gameOver_d;
      winner_q   <= winner_d;
      pointP1_q  <= bus_io.point_p1;
      pointP2_q  <= bus_io.point_p2;
    end
  end

  always_comb begin
    state_d    = state_q;
    scoreP1_d  = scoreP1_q;
    scoreP2_d  = scoreP2_q;
    holdCnt_d  = holdCnt_q;
    serve_d    = 1'b0;
    serveDir_d = serveDir_q;
    gameOver_d = gameOver_q;
    winner_d   = winner_q;

    unique case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          scoreP1_d  = 4'd0;
          scoreP2_d  = 4'd0;
          serveDir_d = 1'b0;
          holdCnt_d  = '0;
          state_d    = HOLDOFF;
        end
      end

      PLAY: begin
        // A simultaneous double event is treated as a replay: no score, same receiver.
        if (eventP1 && eventP2) begin
          holdCnt_d = '0;
          state_d   = HOLDOFF;
        end else if (eventP1) begin
          scoreP1_d  = incP1;
          serveDir_d = 1'b1;
          holdCnt_d  = '0;
          if (incP1 == MaxScore) begin
            winner_d   = 2'b01;
            gameOver_d = 1'b1;
            state_d    = GAME_OVER;
          end else begin
            state_d = HOLDOFF;
          end
        end else if (eventP2) begin
          scoreP2_d  = incP2;
          serveDir_d = 1'b0;
          holdCnt_d  = '0;
          if (incP2 == MaxScore) begin
            winner_d   = 2'b10;
            gameOver_d = 1'b1;
            state_d    = GAME_OVER;
          end else begin
            state_d = HOLDOFF;
          end
        end
      end

      HOLDOFF: begin
        if (holdCnt_q == HoldLast) begin
          serve_d   = 1'b1;
          holdCnt_d = '0;
          state_d   = PLAY;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end

      GAME_OVER: begin
        if (bus_io.start) begin
          scoreP1_d  = 4'd0;
          scoreP2_d  = 4'd0;
          winner_d   = 2'b00;
          gameOver_d = 1'b0;
          holdCnt_d  = '0;
          state_d    = HOLDOFF;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The display copy only moves on frame_tick, so a digit never changes mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shownP1_q <= 4'd0;
      shownP2_q <= 4'd0;
    end else if (bus_io.frame_tick) begin
      shownP1_q <= scoreP1_q;
      shownP2_q <= scoreP2_q;
    end
  end

  assign bus_io.score_p1  = shownP1_q;
  assign bus_io.score_p2  = shownP2_q;
  assign bus_io.serve     = serve_q;
  assign bus_io.serve_dir = serveDir_q;
  assign bus_io.game_over = gameOver_q;
  assign bus_io.winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper. Directed game scenarios and a long random run are checked
// cycle by cycle against a behavioural game model kept inside the bench.
module tb_score_keeper;
  localparam int MAX  = 9;
  localparam int HOLD = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  score_keeper_if bus();

  score_keeper #(.MAX_SCORE(MAX), .HOLDOFF_CYCLES(HOLD), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // The model holds the game as plain scores plus a countdown to the next serve.
  int mScore[2];
  int mShown[2];
  int mWinner;
  int mWaitLeft;
  bit mStarted, mOver, mDir, mServe;
  bit mPrev[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mScore    = '{0, 0};
    mShown    = '{0, 0};
    mWinner   = 0;
    mWaitLeft = 0;
    mStarted  = 1'b0;
    mOver     = 1'b0;
    mDir      = 1'b0;
    mServe    = 1'b0;
    mPrev     = '{1'b0, 1'b0};
  endfunction

  function automatic void modelStep();
    bit pt[2];
    bit ev[2];
    int who;
    pt[0] = bus.point_p1;
    pt[1] = bus.point_p2;
    for (int i = 0; i < 2; i++) begin
      ev[i]    = pt[i] && !mPrev[i];
      mPrev[i] = pt[i];
    end
    if (bus.frame_tick) mShown = mScore;
    mServe = 1'b0;
    if (!mStarted) begin
      if (bus.start) begin
        mStarted  = 1'b1;
        mScore    = '{0, 0};
        mDir      = 1'b0;
        mWaitLeft = HOLD;
      end
    end else if (mOver) begin
      if (bus.start) begin
        mOver     = 1'b0;
        mScore    = '{0, 0};
        mWinner   = 0;
        mWaitLeft = HOLD;
      end
    end else if (mWaitLeft > 0) begin
      mWaitLeft--;
      if (mWaitLeft == 0) mServe = 1'b1;
    end else if (ev[0] && ev[1]) begin
      mWaitLeft = HOLD;
    end else if (ev[0] || ev[1]) begin
      who         = ev[0] ? 0 : 1;
      mScore[who] = (mScore[who] + 1 > MAX) ? MAX : mScore[who] + 1;
      mDir        = (who == 0);
      if (mScore[who] == MAX) begin
        mOver   = 1'b1;
        mWinner = who + 1;
      end else begin
        mWaitLeft = HOLD;
      end
    end
  endfunction

  task automatic compareAll();
    checkOutput("score_p1",  bus.score_p1,  mShown[0]);
    checkOutput("score_p2",  bus.score_p2,  mShown[1]);
    checkOutput("serve",     bus.serve,     mServe);
    checkOutput("serve_dir", bus.serve_dir, mDir);
    checkOutput("game_over", bus.game_over, mOver);
    checkOutput("winner",    bus.winner,    mWinner);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance, then compare.
  task automatic applyStimulus(input bit s, input bit p1, input bit p2, input bit tk);
    bus.start      = s;
    bus.point_p1   = p1;
    bus.point_p2   = p2;
    bus.frame_tick = tk;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic waitServe(input bit p1, input bit p2, output int cyc);
    cyc = 0;
    do begin
      applyStimulus(1'b0, p1, p2, 1'b0);
      cyc++;
    end while (!bus.serve && cyc < 200);
    checkOutput("serveSeen", bus.serve, 1);
  endtask

  // Reset lands between clock edges so the asynchronous clear is visible at once.
  task automatic doReset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstScoreP1",  bus.score_p1,  0);
    checkOutput("rstScoreP2",  bus.score_p2,  0);
    checkOutput("rstServe",    bus.serve,     0);
    checkOutput("rstServeDir", bus.serve_dir, 0);
    checkOutput("rstGameOver", bus.game_over, 0);
    checkOutput("rstWinner",   bus.winner,    0);
    modelReset();
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int serves;
    int serveAt;
    bit rp1, rp2;

    bus.start      = 1'b0;
    bus.point_p1   = 1'b0;
    bus.point_p2   = 1'b0;
    bus.frame_tick = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    compareAll();
    rst_n = 1'b1;

    $display("[TB] start -> serve latency");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitServe(1'b0, 1'b0, cyc);
    checkOutput("startServeLat", cyc + 1, HOLD + 1);
    checkOutput("startServeDir", bus.serve_dir, 0);

    $display("[TB] point_p1 held for 50 cycles");
    serves  = 0;
    serveAt = -1;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (bus.serve) begin
        serves++;
        if (serveAt < 0) serveAt = i;
      end
    end
    checkOutput("heldServes", serves, 1);
    checkOutput("heldServeLat", serveAt + 1, HOLD + 1);
    checkOutput("heldServeDir", bus.serve_dir, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("heldScoreP1", bus.score_p1, 1);
    checkOutput("heldScoreP2", bus.score_p2, 0);

    $display("[TB] simultaneous points replay");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitServe(1'b0, 1'b0, cyc);
    checkOutput("bothServeLat", cyc + 1, HOLD + 1);
    checkOutput("bothServeDir", bus.serve_dir, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bothScoreP1", bus.score_p1, 1);
    checkOutput("bothScoreP2", bus.score_p2, 0);

    $display("[TB] frame-synchronised publishing");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("tickOldValue", bus.score_p2, 0);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("noTickHold", bus.score_p2, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tickNewValue", bus.score_p2, 1);

    $display("[TB] player 2 wins");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      if (k < 7) waitServe(1'b0, 1'b0, cyc);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("overFlag", bus.game_over, 1);
    checkOutput("overWinner", bus.winner, 2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("frozenScoreP1", bus.score_p1, 1);
    checkOutput("frozenScoreP2", bus.score_p2, 9);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("restartWinner", bus.winner, 0);
    checkOutput("restartOver", bus.game_over, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("restartScoreP1", bus.score_p1, 0);
    checkOutput("restartScoreP2", bus.score_p2, 0);

    $display("[TB] reset during hold-off at 3-2");
    waitServe(1'b0, 1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, i < 3, i >= 3, 1'b0);
      if (i < 4) waitServe(1'b0, 1'b0, cyc);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("preRstScoreP1", bus.score_p1, 3);
    checkOutput("preRstScoreP2", bus.score_p2, 2);
    doReset(2);
    serves = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.serve) serves++;
    end
    checkOutput("postRstServes", serves, 0);

    $display("[TB] random play");
    rp1 = 1'b0;
    rp2 = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 1999) == 0) doReset(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) rp1 = ~rp1;
      if ($urandom_range(0, 3) == 0) rp2 = ~rp2;
      applyStimulus($urandom_range(0, 29) == 0, rp1, rp2, $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side producer of the 4-bit score values consumed by the per-player score display components.
- Detects point events from the ball/collision logic and keeps both players' scores (0..MAX_SCORE).
- Sequences serve hold-off and game-over.
- Publishes scores to the display only on frame boundaries so a digit never changes mid-frame.

Parameters:
MAX_SCORE, 9, winning score; legal range 1..9 (display renders single digits).
HOLDOFF_CYCLES, 16, clk cycles between a scored point and the serve request; must be >= 1.
CNT_W, 5, width of the hold-off counter; must satisfy 2^CNT_W > HOLDOFF_CYCLES.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level; new-game request, sampled in IDLE and GAME_OVER.
point_p1  input  1  level from ball logic; ball passed player 2's goal; may stay high many cycles.
point_p2  input  1  level; ball passed player 1's goal.
frame_tick  input  1  one-cycle pulse at start of vertical blanking.
score_p1  output  4  player 1 score to the display, frame-synchronised.
score_p2  output  4  player 2 score to the display, frame-synchronised.
serve  output  1  one-cycle pulse: ball logic recentres and launches the ball.
serve_dir  output  1  0 = toward player 1, 1 = toward player 2; valid with serve and held afterwards.
game_over  output  1  high in GAME_OVER.
winner  output  2  00 none, 01 player 1, 10 player 2.

Behaviour:
- Reset (async, rst_n low) sets:
  - state IDLE;
  - internal scores 0, score_p1/score_p2 0;
  - serve 0, serve_dir 0;
  - game_over 0, winner 00;
  - hold-off counter 0, edge-detect registers 0.
- Rising-edge detection: point_pX registered once; an event is point_pX & ~point_pX_q. Only events count; held levels count once.
- States:
  - IDLE:
    - start=1 -> clear internal scores, serve_dir=0, go to HOLDOFF.
  - PLAY:
    - p1 event only -> p1 score +1, serve_dir=1 (loser player 2 receives), go to HOLDOFF.
    - p2 event only -> p2 score +1, serve_dir=0, go to HOLDOFF.
    - Both events in the same cycle -> neither score changes, serve_dir unchanged, go to HOLDOFF (replay).
    - Increment reaching MAX_SCORE -> GAME_OVER instead of HOLDOFF; winner set the same cycle; game_over=1 next cycle.
  - HOLDOFF:
    - Counter counts 0..HOLDOFF_CYCLES-1; point events ignored.
    - On the terminal count: serve=1 for exactly one cycle, counter cleared, go to PLAY.
  - GAME_OVER:
    - Scores frozen; point events ignored; game_over=1.
    - start=1 -> clear internal scores, winner=00, game_over=0, go to HOLDOFF.
    - start held continuously in PLAY/HOLDOFF has no effect.
- Arithmetic: internal scores saturate at MAX_SCORE and never exceed 9.
- Display shadow:
  - score_p1/score_p2 update only in the cycle after frame_tick=1, copying the internal scores.
  - Between ticks the outputs are stable.
  - The first published value after a new game appears at the next frame_tick.
- Simultaneous events:
  - frame_tick in the same cycle as a score increment publishes the pre-increment value; the new value waits for the next tick.
  - start and a point event in the same GAME_OVER cycle: start wins.
- Latency:
  - point edge -> internal increment: 1 cycle after the registered edge.
  - Increment -> serve: HOLDOFF_CYCLES+1 cycles.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values; no serve pulse is emitted.

Test Plan:
- Reset, start pulse -> serve pulse exactly HOLDOFF_CYCLES+1 cycles later, serve_dir=0; score_p1=score_p2=0.
- In PLAY, point_p1 held high 50 cycles, then frame_tick -> score_p1=1 (single count); serve after hold-off; serve_dir=1.
- Default MAX_SCORE=9: alternate nine p2 points with serves -> game_over=1, winner=10; later point_p1 pulses leave scores 0/9; start -> scores 0, winner=00.
- point_p1 and point_p2 rising together in PLAY -> no score change, serve after hold-off, serve_dir unchanged.
- Score increment with no frame_tick for 1000 cycles -> outputs unchanged; next frame_tick -> new value the following cycle; tick coincident with increment -> old value published.
- Assert rst_n low during HOLDOFF with score 3-2 -> all outputs 0 at once, no serve; after release, state IDLE awaiting start.
